// File: rtl/shifter_seq.sv
// Sequential shifter: shift/rotate ops on the held data value, advancing up to
// STEP bit positions per clock, with busy during the shift and a one-cycle done.
module shifter_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    localparam int unsigned SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SW-1:0]    shamt,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_LSL   = 3'd2;
    localparam logic [2:0] OP_LSR   = 3'd3;
    localparam logic [2:0] OP_ASR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_ROR   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SW-1:0] STEP_W = SW'(STEP);

    logic [1:0]       state_q, state_nxt;
    logic [SW-1:0]    rem_q, rem_nxt;
    logic [2:0]       op_q, op_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic [SW-1:0]    step_n;

    // One shift/rotate of v by n positions; rotates use a doubled word to wrap.
    function automatic logic [WIDTH-1:0] shift_val(input logic [2:0] o,
                                                   input logic [WIDTH-1:0] v,
                                                   input logic [SW-1:0] n);
        logic [2*WIDTH-1:0] dbl;
        dbl = {v, v};
        case (o)
            OP_LSL:  shift_val = v << n;
            OP_LSR:  shift_val = v >> n;
            OP_ASR:  shift_val = WIDTH'($signed(v) >>> n);
            OP_ROL: begin
                dbl       = dbl << n;
                shift_val = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl       = dbl >> n;
                shift_val = dbl[WIDTH-1:0];
            end
            default: shift_val = v;
        endcase
    endfunction

    // Next-state, next-data and remaining-count logic
    always_comb begin
        state_nxt = state_q;
        rem_nxt   = rem_q;
        op_nxt    = op_q;
        d_nxt     = d_out;
        step_n    = (rem_q < STEP_W) ? rem_q : STEP_W;
        case (state_q)
            S_SHIFT: begin
                d_nxt   = shift_val(op_q, d_out, step_n);
                rem_nxt = rem_q - step_n;
                if (rem_nxt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (start) begin
                    if ((op >= OP_LSL) && (op <= OP_ROR) && (shamt != '0)) begin
                        rem_nxt   = shamt;
                        op_nxt    = op;
                        state_nxt = S_SHIFT;
                    end else begin
                        state_nxt = S_DONE;
                        case (op)
                            OP_LOAD:  d_nxt = d_in;
                            OP_CLEAR: d_nxt = '0;
                            default:  d_nxt = d_out;
                        endcase
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rem_nxt   = '0;
            end
        endcase
    end

    // State, data and status registers; status flags follow the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            d_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            rem_q   <= rem_nxt;
            op_q    <= op_nxt;
            d_out   <= d_nxt;
            busy    <= (state_nxt == S_SHIFT);
            done    <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: two instances (STEP=1 and STEP=3) checked against a
// net-shift reference model with directed scenarios and random ops.
module tb_shifter_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [2];
    logic [2:0] op    [2];
    logic [2:0] shamt [2];
    logic [7:0] d_in  [2];
    logic [7:0] d_out [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] md    [2];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    shifter_seq #(.WIDTH(8), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start[0]), .op(op[0]), .shamt(shamt[0]),
        .d_in(d_in[0]), .d_out(d_out[0]), .busy(busy[0]), .done(done[0])
    );

    shifter_seq #(.WIDTH(8), .STEP(3)) u_s3 (
        .clk(clk), .reset(reset), .start(start[1]), .op(op[1]), .shamt(shamt[1]),
        .d_in(d_in[1]), .d_out(d_out[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int stp(input bit s);
        return s ? 3 : 1;
    endfunction

    // Result of applying op once, with the full amount, to value v
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] v,
                                          input int amt, input logic [7:0] din);
        int x;
        x = int'(v);
        case (o)
            3'd0:    return v;
            3'd1:    return din;
            3'd2:    return 8'(x << amt);
            3'd3:    return 8'(x >> amt);
            3'd4:    return 8'((x >> amt) | (v[7] ? (255 << (8 - amt)) : 0));
            3'd5:    return 8'((x << amt) | (x >> (8 - amt)));
            3'd6:    return 8'((x >> amt) | (x << (8 - amt)));
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input bit s, input string tag, input logic b,
                              input logic dn, input logic [7:0] dv);
        chk({tag, ".busy"}, {7'b0, busy[s]}, {7'b0, b});
        chk({tag, ".done"}, {7'b0, done[s]}, {7'b0, dn});
        chk({tag, ".d_out"}, d_out[s], dv);
    endtask

    // Issue one request and check every cycle until the instance is idle again
    task automatic run_op(input bit s, input logic [2:0] o, input int amt,
                          input logic [7:0] din, input string tag);
        int c;
        int a;
        logic [7:0] orig;
        logic [7:0] fin;
        orig = md[s];
        fin  = ref_op(o, orig, amt, din);
        c    = (o >= 3'd2 && o <= 3'd6 && amt > 0) ? (amt + stp(s) - 1) / stp(s) : 0;
        start[s] = 1'b1; op[s] = o; shamt[s] = 3'(amt); d_in[s] = din;
        tick();
        start[s] = 1'b0;
        for (int k = 0; k < c; k++) begin
            a = (k * stp(s) < amt) ? k * stp(s) : amt;
            expect_out(s, tag, 1'b1, 1'b0, ref_op(o, orig, a, din));
            start[s] = 1'($urandom);
            op[s]    = 3'($urandom);
            shamt[s] = 3'($urandom);
            d_in[s]  = 8'($urandom);
            tick();
        end
        start[s] = 1'b0;
        expect_out(s, tag, 1'b0, 1'b1, fin);
        md[s] = fin;
        tick();
        expect_out(s, tag, 1'b0, 1'b0, fin);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b1; op[i] = 3'd1; shamt[i] = 3'd0; d_in[i] = 8'hFF;
            md[i] = 8'h00;
        end
        tick();
        tick();
        expect_out(1'b0, "reset_s1", 1'b0, 1'b0, 8'h00);
        expect_out(1'b1, "reset_s3", 1'b0, 1'b0, 8'h00);
        start[1] = 1'b0;
        reset    = 1'b0;

        // First request accepted at the first edge out of reset
        run_op(1'b0, 3'd1, 0, 8'hA5, "load_a5");

        run_op(1'b0, 3'd1, 0, 8'h81, "load_81");
        run_op(1'b0, 3'd4, 3, 8'h00, "asr3_s1");

        run_op(1'b1, 3'd1, 0, 8'h81, "load_81_s3");
        run_op(1'b1, 3'd5, 7, 8'h00, "rol7_s3");

        run_op(1'b0, 3'd1, 0, 8'h5A, "load_5a");
        run_op(1'b0, 3'd3, 0, 8'h00, "lsr0");

        // Start during SHIFT is ignored; start in DONE is accepted
        run_op(1'b0, 3'd1, 0, 8'h81, "load_81b");
        start[0] = 1'b1; op[0] = 3'd4; shamt[0] = 3'd3;
        tick();
        expect_out(1'b0, "ign_sh0", 1'b1, 1'b0, 8'h81);
        op[0] = 3'd1; d_in[0] = 8'hFF; shamt[0] = 3'd0;
        tick();
        start[0] = 1'b0;
        expect_out(1'b0, "ign_sh1", 1'b1, 1'b0, 8'hC0);
        tick();
        expect_out(1'b0, "ign_sh2", 1'b1, 1'b0, 8'hE0);
        tick();
        expect_out(1'b0, "ign_done", 1'b0, 1'b1, 8'hF0);
        start[0] = 1'b1; op[0] = 3'd1; d_in[0] = 8'h3C;
        tick();
        start[0] = 1'b0;
        expect_out(1'b0, "acc_in_done", 1'b0, 1'b1, 8'h3C);
        tick();
        expect_out(1'b0, "acc_idle", 1'b0, 1'b0, 8'h3C);
        md[0] = 8'h3C;

        // Reset in the second SHIFT cycle of LSL 5 on 0xFF
        run_op(1'b0, 3'd1, 0, 8'hFF, "load_ff");
        start[0] = 1'b1; op[0] = 3'd2; shamt[0] = 3'd5;
        tick();
        start[0] = 1'b0;
        expect_out(1'b0, "rst_sh0", 1'b1, 1'b0, 8'hFF);
        tick();
        expect_out(1'b0, "rst_sh1", 1'b1, 1'b0, 8'hFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        md[0] = 8'h00;
        md[1] = 8'h00;
        expect_out(1'b0, "rst_mid", 1'b0, 1'b0, 8'h00);
        expect_out(1'b1, "rst_mid_s3", 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out(1'b0, "rst_after", 1'b0, 1'b0, 8'h00);
        end

        // Start held high: accepted in every DONE cycle, ignored in SHIFT
        start[0] = 1'b1; op[0] = 3'd1; shamt[0] = 3'd0; d_in[0] = 8'h96;
        tick();
        expect_out(1'b0, "b2b_load", 1'b0, 1'b1, 8'h96);
        op[0] = 3'd6; shamt[0] = 3'd1;
        tick();
        expect_out(1'b0, "b2b_ror_sh", 1'b1, 1'b0, 8'h96);
        op[0] = 3'd7;
        tick();
        expect_out(1'b0, "b2b_ror_done", 1'b0, 1'b1, 8'h4B);
        tick();
        start[0] = 1'b0;
        expect_out(1'b0, "b2b_clear", 1'b0, 1'b1, 8'h00);
        tick();
        expect_out(1'b0, "b2b_idle", 1'b0, 1'b0, 8'h00);
        md[0] = 8'h00;

        // Random ops on both instances
        for (int i = 0; i < 120; i++) begin
            bit s;
            logic [2:0] o;
            s = 1'($urandom_range(0, 1));
            o = 3'($urandom_range(0, 7));
            if (md[s] == 8'h00 && o != 3'd1) begin
                run_op(s, 3'd1, 0, 8'($urandom), "rnd_load");
            end
            run_op(s, o, int'($urandom_range(0, 7)), 8'($urandom), "rnd_op");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
